// File: rtl/countdown_timer_pkg.sv
// Shared constants, state encoding and helpers for the MM:SS BCD countdown timer.
package countdown_timer_pkg;

  localparam int unsigned BCD_BIT_WIDTH = 4;
  localparam int unsigned NUM_DIGITS    = 4;

  localparam logic [BCD_BIT_WIDTH-1:0] BCD_ZERO = 4'd0;
  localparam logic [BCD_BIT_WIDTH-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  // Out-of-range load digits saturate at the digit's wrap value.
  function automatic logic [BCD_BIT_WIDTH-1:0] clamp_digit(
    input logic [BCD_BIT_WIDTH-1:0] d,
    input logic [BCD_BIT_WIDTH-1:0] lim
  );
    return (d > lim) ? lim : d;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_downcounter.sv
// Single BCD digit down counter with synchronous load and combinational borrow.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   decrease_i      count down by one this cycle
//   load_i          replace value with load_value_i (priority over decrease_i)
//   load_value_i    value to load (already clamped by the parent)
//   limit_i         value taken when counting down from zero
//   value_o         current digit value
//   borrow_o        high when counting down from zero (feeds next digit)
module countdown_timer_bcd_downcounter
  import countdown_timer_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     decrease_i,
  input  logic                     load_i,
  input  logic [BCD_BIT_WIDTH-1:0] load_value_i,
  input  logic [BCD_BIT_WIDTH-1:0] limit_i,
  output logic [BCD_BIT_WIDTH-1:0] value_o,
  output logic                     borrow_o
);

  logic [BCD_BIT_WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d  = value_q;
    borrow_o = 1'b0;
    if (load_i) begin
      value_d = load_value_i;
    end else if (decrease_i) begin
      if (value_q == BCD_ZERO) begin
        value_d  = limit_i;
        borrow_o = 1'b1;
      end else begin
        value_d = value_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= BCD_ZERO;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: four cascaded BCD down counters paced by a 1 Hz tick,
// controlled by an IDLE/RUN/PAUSE/DONE state machine.
// Ports:
//   clk_i, rst_ni   clock, async active-low reset
//   tick_i          one-cycle 1 Hz count enable
//   start_pause_i   one-cycle pulse: start, pause, resume, or acknowledge done
//   load_i          one-cycle pulse: load load_value_i and return to IDLE
//   load_value_i    {min_tens, min_ones, sec_tens, sec_ones} BCD
//   digits_o        current {min_tens, min_ones, sec_tens, sec_ones}
//   running_o       high in RUN
//   done_o          high in DONE
//   done_pulse_o    one-cycle pulse on entry to DONE
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter logic [3:0] SEC_TENS_LIMIT = 4'd5,
  parameter logic [3:0] MIN_TENS_LIMIT = 4'd5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        tick_i,
  input  logic        start_pause_i,
  input  logic        load_i,
  input  logic [15:0] load_value_i,
  output logic [15:0] digits_o,
  output logic        running_o,
  output logic        done_o,
  output logic        done_pulse_o
);

  state_e state_q, state_d;
  logic   done_pulse_q, done_pulse_d;

  logic [NUM_DIGITS-1:0][BCD_BIT_WIDTH-1:0] limit;
  logic [NUM_DIGITS-1:0][BCD_BIT_WIDTH-1:0] value;
  logic [NUM_DIGITS-1:0]                    dec;
  logic [NUM_DIGITS-1:0]                    borrow;
  logic                                     digits_zero;
  logic                                     unused_borrow;

  assign limit[0] = BCD_NINE;
  assign limit[1] = SEC_TENS_LIMIT;
  assign limit[2] = BCD_NINE;
  assign limit[3] = MIN_TENS_LIMIT;

  assign digits_zero = (value == '0);

  // Zero guard keeps 00:00 from wrapping to 59:59.
  assign dec[0] = tick_i && (state_q == StRun) && !digits_zero;

  for (genvar k = 1; k < NUM_DIGITS; k++) begin : g_chain
    assign dec[k] = borrow[k-1];
  end

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    countdown_timer_bcd_downcounter u_digit (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .decrease_i   (dec[k]),
      .load_i       (load_i),
      .load_value_i (clamp_digit(load_value_i[k*BCD_BIT_WIDTH +: BCD_BIT_WIDTH], limit[k])),
      .limit_i      (limit[k]),
      .value_o      (value[k]),
      .borrow_o     (borrow[k])
    );
  end

  assign unused_borrow = borrow[NUM_DIGITS-1];

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  if (start_pause_i && !digits_zero) state_d = StRun;
        // Reaching zero wins over a coincident pause request.
        StRun: begin
          if (digits_zero)        state_d = StDone;
          else if (start_pause_i) state_d = StPause;
        end
        StPause: if (start_pause_i) state_d = StRun;
        StDone:  if (start_pause_i) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    done_pulse_d = (state_q == StRun) && (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign digits_o     = value;
  assign running_o    = (state_q == StRun);
  assign done_o       = (state_q == StDone);
  assign done_pulse_o = done_pulse_q;

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        start_pause = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;
  logic [15:0] digits;
  logic        running, done, done_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  countdown_timer dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .tick_i        (tick),
    .start_pause_i (start_pause),
    .load_i        (load),
    .load_value_i  (load_value),
    .digits_o      (digits),
    .running_o     (running),
    .done_o        (done),
    .done_pulse_o  (done_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: time held as whole minutes and seconds.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_min, m_sec, m_st;
  bit m_pulse;

  function automatic int clamp(input int d, input int lim);
    return (d > lim) ? lim : d;
  endfunction

  task automatic model_reset();
    m_min = 0; m_sec = 0; m_st = M_IDLE; m_pulse = 0;
  endtask

  task automatic model_edge(input bit t, input bit sp, input bit ld, input logic [15:0] v);
    int nst;
    bit was_zero;
    was_zero = (m_min == 0) && (m_sec == 0);
    nst = m_st;
    if (ld) begin
      m_min = clamp(int'(v[15:12]), 5) * 10 + clamp(int'(v[11:8]), 9);
      m_sec = clamp(int'(v[7:4]), 5) * 10 + clamp(int'(v[3:0]), 9);
      nst = M_IDLE;
    end else begin
      if (t && m_st == M_RUN && !was_zero) begin
        if (m_sec > 0) m_sec = m_sec - 1;
        else begin m_sec = 59; m_min = m_min - 1; end
      end
      case (m_st)
        M_IDLE:  if (sp && !was_zero) nst = M_RUN;
        M_RUN:   if (was_zero) nst = M_DONE; else if (sp) nst = M_PAUSE;
        M_PAUSE: if (sp) nst = M_RUN;
        default: if (sp) nst = M_IDLE;
      endcase
    end
    m_pulse = (m_st == M_RUN) && (nst == M_DONE);
    m_st = nst;
  endtask

  function automatic logic [18:0] exp_vec();
    logic [15:0] d;
    d = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    return {d, (m_st == M_RUN), (m_st == M_DONE), m_pulse};
  endfunction

  // Drive one cycle of inputs, advance through the edge, sample 1 time unit later.
  task automatic step(input bit t, input bit sp, input bit ld, input logic [15:0] v);
    tick = t; start_pause = sp; load = ld; load_value = v;
    @(posedge clk);
    model_edge(t, sp, ld, v);
    #1;
    tick = 0; start_pause = 0; load = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick = 1; start_pause = i[0]; @(posedge clk); #1;
    end
    tick = 0; start_pause = 0;
    n_checks++;
    if ({digits, running, done, done_pulse} !== 19'h0)
      $display("FAIL reset_held: got %h want %h", {digits, running, done, done_pulse}, 19'h0);
    else n_pass++;
    @(negedge clk); rst_n = 1;
    step(1, 0, 0, 16'h0);
    n_checks++;
    if ({digits, running, done, done_pulse} !== 19'h0)
      $display("FAIL reset_release: got %h want %h", {digits, running, done, done_pulse}, 19'h0);
    else n_pass++;
  endtask

  task automatic test_single_tick();
    step(0, 0, 1, 16'h0100);
    step(0, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    n_checks++;
    if ({digits, running} !== {16'h0059, 1'b1} || exp_vec() !== {16'h0059, 3'b100})
      $display("FAIL single_tick: got %h/%b want 0059/1", digits, running);
    else n_pass++;
  endtask

  task automatic test_ripple();
    step(0, 0, 1, 16'h1000);
    step(0, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    n_checks++;
    if (digits !== 16'h0959)
      $display("FAIL ripple: got %h want 0959", digits);
    else n_pass++;
  endtask

  task automatic test_done();
    step(0, 0, 1, 16'h0002);
    step(0, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    n_checks++;
    if (digits !== 16'h0001) $display("FAIL done_first_tick: got %h want 0001", digits);
    else n_pass++;
    step(1, 0, 0, 16'h0);
    n_checks++;
    if ({digits, done} !== {16'h0000, 1'b0})
      $display("FAIL done_zero_reached: got %h/%b want 0000/0", digits, done);
    else n_pass++;
    step(0, 0, 0, 16'h0);
    n_checks++;
    if ({done, done_pulse, running} !== 3'b110)
      $display("FAIL done_entry: got %b want 110", {done, done_pulse, running});
    else n_pass++;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0);
    n_checks++;
    if ({digits, done, done_pulse} !== {16'h0000, 2'b10})
      $display("FAIL done_hold: got %h/%b want 0000/10", digits, {done, done_pulse});
    else n_pass++;
    step(0, 1, 0, 16'h0);
    n_checks++;
    if ({done, running} !== 2'b00 || exp_vec() !== 19'h0)
      $display("FAIL done_ack: got %b want 00", {done, running});
    else n_pass++;
  endtask

  task automatic test_pause();
    step(0, 0, 1, 16'h0030);
    step(0, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0);
    n_checks++;
    if ({digits, running} !== {16'h0029, 1'b0})
      $display("FAIL pause_hold: got %h/%b want 0029/0", digits, running);
    else n_pass++;
    step(0, 1, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    n_checks++;
    if ({digits, running} !== {16'h0028, 1'b1})
      $display("FAIL pause_resume: got %h/%b want 0028/1", digits, running);
    else n_pass++;
  endtask

  task automatic test_clamp();
    step(1, 1, 1, 16'h7A9F);
    n_checks++;
    if ({digits, running, done} !== {16'h5959, 2'b00})
      $display("FAIL clamp_load: got %h/%b want 5959/00", digits, {running, done});
    else n_pass++;
  endtask

  task automatic test_reset_midrun();
    step(0, 0, 1, 16'h0010);
    step(0, 1, 0, 16'h0);
    #2 rst_n = 0;
    model_reset();
    #1;
    n_checks++;
    if ({digits, running, done, done_pulse} !== 19'h0)
      $display("FAIL reset_midrun: got %h want %h", {digits, running, done, done_pulse}, 19'h0);
    else n_pass++;
    @(negedge clk); rst_n = 1;
    step(1, 1, 0, 16'h0);
    n_checks++;
    if ({digits, running, done, done_pulse} !== 19'h0)
      $display("FAIL reset_midrun_after: got %h want %h",
               {digits, running, done, done_pulse}, 19'h0);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] v;
    bit t, sp, ld;
    for (int i = 0; i < 600; i++) begin
      t  = ($urandom_range(0, 1) == 1);
      sp = ($urandom_range(0, 9) == 0);
      ld = ($urandom_range(0, 29) == 0);
      v  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 25));
      step(t, sp, ld, v);
      n_checks++;
      if ({digits, running, done, done_pulse} !== exp_vec())
        $display("FAIL random_cycle_%0d: got %h want %h", i,
                 {digits, running, done, done_pulse}, exp_vec());
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_tick();
    test_ripple();
    test_done();
    test_pause();
    test_clamp();
    test_reset_midrun();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
